// File: rtl/slc3_io_pkg.sv
// ---------------------------------------------------------------------------
// slc3_io_pkg
// Shared types and defaults for the SLC-3 front-panel input controller.
//   btn_state_t        : per-button debounce FSM states
//   DEF_* constants    : default values of the controller parameters
//   cnt_width()        : width of a counter that must hold values 0..n-1
// ---------------------------------------------------------------------------
package slc3_io_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_CYCLES   = 64;

    // A counter that only ever reaches n-1 needs clog2(n) bits, but never
    // fewer than one so that degenerate parameter values still elaborate.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slc3_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// slc3_input_ctrl_if
// Bundle of the front-panel signals exchanged between the board side and
// the input controller.
//   Run_n, Continue_n : raw active-low pushbuttons (asynchronous)
//   S_in              : raw 16-bit switch bank (asynchronous)
//   S                 : synchronized switches toward the processor
//   run_pulse         : one-cycle Run strobe
//   continue_pulse    : one-cycle Continue strobe
//   run_held          : Run is debounced-pressed
// Modports:
//   master : the board/stimulus side (drives raw inputs, observes outputs)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface slc3_input_ctrl_if;

    logic        Run_n;
    logic        Continue_n;
    logic [15:0] S_in;
    logic [15:0] S;
    logic        run_pulse;
    logic        continue_pulse;
    logic        run_held;

    modport master (
        output Run_n,
        output Continue_n,
        output S_in,
        input  S,
        input  run_pulse,
        input  continue_pulse,
        input  run_held
    );

    modport slave (
        input  Run_n,
        input  Continue_n,
        input  S_in,
        output S,
        output run_pulse,
        output continue_pulse,
        output run_held
    );

endinterface

// File: rtl/slc3_input_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronizes one raw active-low pushbutton, debounces it with a
// four-state FSM and produces a one-cycle strobe on each accepted press.
// Optionally re-strobes periodically while the button stays held.
// Parameters:
//   SYNC_STAGES     : synchronizer depth (2 or more)
//   DEBOUNCE_CYCLES : stable cycles needed to accept a press or a release
//   REPEAT_CYCLES   : autorepeat period in cycles spent in HELD
//   REPEAT_EN       : enables the autorepeat strobe
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : asynchronous active-high reset
//   btn_n : raw button level, 0 = pressed
//   pulse : one-cycle strobe (first cycle of HELD, plus autorepeats)
//   held  : high in HELD and RELEASE_WAIT
// ---------------------------------------------------------------------------
module btn_debounce
    import slc3_io_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pulse,
    output logic held
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int RP_W = cnt_width(REPEAT_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    btn_state_t             state_q, state_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [RP_W-1:0]        rep_cnt_q, rep_cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   pressed;

    // Shift chain; bit 0 takes the raw level, the top bit is the safe copy.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_n};
    end

    assign pressed = ~sync_q[SYNC_STAGES-1];

    // Debounce FSM. The counters only advance while below their last value,
    // so they saturate instead of wrapping. The strobe is registered so it
    // lines up with the first cycle spent in HELD.
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rep_cnt_d = rep_cnt_q;
        pulse_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = HELD;
                    pulse_d   = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d   = RELEASE_WAIT;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                end else if (REPEAT_EN) begin
                    if (rep_cnt_q == RP_LAST) begin
                        pulse_d   = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RP_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed resumes HELD silently.
                if (pressed) begin
                    state_d  = HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    // Synchronizer resets to the released level so a button held across
    // reset is seen as a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign held  = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/slc3_input_ctrl.sv
// ---------------------------------------------------------------------------
// slc3_input_ctrl
// Front-panel input controller for the SLC-3: synchronizes the switch bank
// and debounces the Run and Continue pushbuttons into one-cycle strobes.
// Parameters: SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_CYCLES
// Ports:
//   Clk   : single clock, rising edge
//   Reset : asynchronous active-high reset
//   io    : slc3_input_ctrl_if.slave (Run_n, Continue_n, S_in in;
//           S, run_pulse, continue_pulse, run_held out)
// Build option:
//   CONT_AUTOREPEAT_EN : when defined, Continue re-strobes every
//                        REPEAT_CYCLES cycles while held. Run never repeats.
// ---------------------------------------------------------------------------
module slc3_input_ctrl
    import slc3_io_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic             Clk,
    input  logic             Reset,
    slc3_input_ctrl_if.slave io
);

`ifdef CONT_AUTOREPEAT_EN
    localparam bit CONT_REPEAT_EN = 1'b1;
`else
    localparam bit CONT_REPEAT_EN = 1'b0;
`endif

    logic [SYNC_STAGES-1:0][15:0] s_sync_q, s_sync_d;

    // Switches are only synchronized, not debounced; the processor reads
    // them as a level.
    always_comb begin
        s_sync_d = {s_sync_q[SYNC_STAGES-2:0], io.S_in};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s_sync_q <= '0;
        end else begin
            s_sync_q <= s_sync_d;
        end
    end

    assign io.S = s_sync_q[SYNC_STAGES-1];

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b0)
    ) u_run (
        .clk   (Clk),
        .rst   (Reset),
        .btn_n (io.Run_n),
        .pulse (io.run_pulse),
        .held  (io.run_held)
    );

    // The Continue held flag has no consumer; only its strobe is exported.
    logic cont_held;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (CONT_REPEAT_EN)
    ) u_cont (
        .clk   (Clk),
        .rst   (Reset),
        .btn_n (io.Continue_n),
        .pulse (io.continue_pulse),
        .held  (cont_held)
    );

endmodule

// File: tb/tb_slc3_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_slc3_input_ctrl
// Self-checking bench for slc3_input_ctrl with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8. A behavioural model predicts every
// output each cycle; directed scenarios add hand-computed expectations.
// Honors CONT_AUTOREPEAT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_slc3_input_ctrl;

    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RP = 8;
`ifdef CONT_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam int EXP_EXTRA = AR ? 3 : 0;

    logic Clk = 1'b0;
    logic Reset;

    slc3_input_ctrl_if io ();

    slc3_input_ctrl #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .io    (io)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int run_cnt  = 0;
    int cont_cnt = 0;
    bit check_en = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a button is accepted once its synchronized level has been
    // pressed for DB+1 consecutive samples, and dropped after DB+1
    // consecutive released samples. Index 0 = Run, 1 = Continue.
    bit          m_pipe  [2][SS];
    logic [15:0] m_spipe [SS];
    int          m_run_len [2];
    int          m_rel_len [2];
    int          m_rep     [2];
    bit          m_db      [2];
    bit          m_prev_p  [2];
    bit          m_pulse   [2];
    logic [15:0] m_s;

    always @(posedge Clk or posedge Reset) begin
        bit raw;
        bit p;
        if (Reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < SS; k++) m_pipe[b][k] = 1'b1;
                m_run_len[b] = 0;
                m_rel_len[b] = 0;
                m_rep[b]     = 0;
                m_db[b]      = 1'b0;
                m_prev_p[b]  = 1'b0;
                m_pulse[b]   = 1'b0;
            end
            for (int k = 0; k < SS; k++) m_spipe[k] = 16'h0;
            m_s = 16'h0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                raw = (b == 0) ? io.Run_n : io.Continue_n;
                p   = ~m_pipe[b][SS-1];
                for (int k = SS-1; k > 0; k--) m_pipe[b][k] = m_pipe[b][k-1];
                m_pipe[b][0] = raw;
                m_pulse[b] = 1'b0;
                if (p) begin
                    m_run_len[b]++;
                    m_rel_len[b] = 0;
                end else begin
                    m_rel_len[b]++;
                    m_run_len[b] = 0;
                end
                if (!m_db[b]) begin
                    if (m_run_len[b] == DB + 1) begin
                        m_db[b]    = 1'b1;
                        m_pulse[b] = 1'b1;
                        m_rep[b]   = 0;
                    end
                end else if (p) begin
                    if (m_prev_p[b]) begin
                        m_rep[b]++;
                        if (AR && b == 1 && m_rep[b] == RP) begin
                            m_pulse[b] = 1'b1;
                            m_rep[b]   = 0;
                        end
                    end else begin
                        m_rep[b] = 0;
                    end
                end else begin
                    m_rep[b] = 0;
                    if (m_rel_len[b] == DB + 1) m_db[b] = 1'b0;
                end
                m_prev_p[b] = p;
            end
            for (int k = SS-1; k > 0; k--) m_spipe[k] = m_spipe[k-1];
            m_spipe[0] = io.S_in;
            m_s = m_spipe[SS-1];
        end
    end

    // Compare every cycle on the falling edge, clear of the active edge.
    always @(negedge Clk) begin
        if (check_en) begin
            check_output("cmp_run_pulse", {31'b0, io.run_pulse}, {31'b0, m_pulse[0]});
            check_output("cmp_cont_pulse", {31'b0, io.continue_pulse}, {31'b0, m_pulse[1]});
            check_output("cmp_run_held", {31'b0, io.run_held}, {31'b0, m_db[0]});
            check_output("cmp_S", {16'b0, io.S}, {16'b0, m_s});
            if (io.run_pulse) run_cnt++;
            if (io.continue_pulse) cont_cnt++;
        end
    end

    // Wait n rising edges, then settle 2 time units past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic run_n, input logic cont_n,
                                  input logic [15:0] s_in, input int edges);
        io.Run_n      = run_n;
        io.Continue_n = cont_n;
        io.S_in       = s_in;
        step(edges);
    endtask

    int r0;
    int c0;
    int c1;

    initial begin
        Reset = 1'b1;
        io.Run_n = 1'b1;
        io.Continue_n = 1'b1;
        io.S_in = 16'h0;
        step(3);
        check_en = 1'b1;

        check_output("rst_S", {16'b0, io.S}, 32'h0);
        check_output("rst_run_pulse", {31'b0, io.run_pulse}, 32'h0);
        check_output("rst_cont_pulse", {31'b0, io.continue_pulse}, 32'h0);
        check_output("rst_run_held", {31'b0, io.run_held}, 32'h0);
        Reset = 1'b0;
        step(2);

        // Run held low 20 cycles: strobe on edge 7, held drops on release edge 7.
        r0 = run_cnt;
        apply_stimulus(1'b0, 1'b1, 16'h0, 6);
        check_output("run_edge6_pulse", {31'b0, io.run_pulse}, 32'h0);
        check_output("run_edge6_held", {31'b0, io.run_held}, 32'h0);
        step(1);
        check_output("run_edge7_pulse", {31'b0, io.run_pulse}, 32'h1);
        check_output("run_edge7_held", {31'b0, io.run_held}, 32'h1);
        step(1);
        check_output("run_edge8_pulse", {31'b0, io.run_pulse}, 32'h0);
        step(12);
        apply_stimulus(1'b1, 1'b1, 16'h0, 6);
        check_output("run_rel6_held", {31'b0, io.run_held}, 32'h1);
        step(1);
        check_output("run_rel7_held", {31'b0, io.run_held}, 32'h0);
        step(2);
        check_output("run_single_strobe", run_cnt - r0, 32'd1);

        // Short Continue press is rejected.
        c0 = cont_cnt;
        apply_stimulus(1'b1, 1'b0, 16'h0, 3);
        apply_stimulus(1'b1, 1'b1, 16'h0, 12);
        check_output("cont_short_none", cont_cnt - c0, 32'd0);

        // Release bounce while HELD: no second strobe, held stays up.
        r0 = run_cnt;
        apply_stimulus(1'b0, 1'b1, 16'h0, 10);
        check_output("bounce_pre_held", {31'b0, io.run_held}, 32'h1);
        apply_stimulus(1'b1, 1'b1, 16'h0, 2);
        apply_stimulus(1'b0, 1'b1, 16'h0, 1);
        check_output("bounce_mid_held", {31'b0, io.run_held}, 32'h1);
        step(11);
        check_output("bounce_post_held", {31'b0, io.run_held}, 32'h1);
        check_output("bounce_one_strobe", run_cnt - r0, 32'd1);
        apply_stimulus(1'b1, 1'b1, 16'h0, 10);
        check_output("bounce_released", {31'b0, io.run_held}, 32'h0);

        // Switch synchronization: two-edge latency.
        apply_stimulus(1'b1, 1'b1, 16'h0003, 1);
        check_output("s3_edge1", {16'b0, io.S}, 32'h0);
        step(1);
        check_output("s3_edge2", {16'b0, io.S}, 32'h0003);
        apply_stimulus(1'b1, 1'b1, 16'h0005, 1);
        check_output("s5_edge1", {16'b0, io.S}, 32'h0003);
        step(1);
        check_output("s5_edge2", {16'b0, io.S}, 32'h0005);

        // Reset during PRESS_WAIT with Run held: progress discarded.
        r0 = run_cnt;
        apply_stimulus(1'b0, 1'b1, 16'h0005, 4);
        Reset = 1'b1;
        #1;
        check_output("midrst_S", {16'b0, io.S}, 32'h0);
        check_output("midrst_run_pulse", {31'b0, io.run_pulse}, 32'h0);
        check_output("midrst_run_held", {31'b0, io.run_held}, 32'h0);
        step(2);
        Reset = 1'b0;
        step(6);
        check_output("midrst_edge6_pulse", {31'b0, io.run_pulse}, 32'h0);
        step(1);
        check_output("midrst_edge7_pulse", {31'b0, io.run_pulse}, 32'h1);
        step(3);
        check_output("midrst_one_strobe", run_cnt - r0, 32'd1);
        apply_stimulus(1'b1, 1'b1, 16'h0005, 10);

        // Simultaneous press, Continue held 30 cycles past its first strobe.
        r0 = run_cnt;
        c0 = cont_cnt;
        apply_stimulus(1'b0, 1'b0, 16'h0005, 6);
        check_output("both_edge6_cont", {31'b0, io.continue_pulse}, 32'h0);
        step(1);
        check_output("both_edge7_run", {31'b0, io.run_pulse}, 32'h1);
        check_output("both_edge7_cont", {31'b0, io.continue_pulse}, 32'h1);
        step(1);
        c1 = cont_cnt;
        check_output("both_first_cont", c1 - c0, 32'd1);
        step(29);
        check_output("cont_repeat_extra", cont_cnt - c1, EXP_EXTRA);
        check_output("run_no_repeat", run_cnt - r0, 32'd1);
        apply_stimulus(1'b1, 1'b1, 16'h0005, 12);
        check_output("final_run_held", {31'b0, io.run_held}, 32'h0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
